// File: rtl/axil_write_arbiter.sv
// rtl/axil_write_arbiter.sv - two-requester AXI-Lite write arbiter; ARB_FIXED_PRIORITY_EN gives requester 0 every tie
module axil_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 2
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,
    input  logic [2*ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [1:0]                s_axi_awvalid,
    output logic [1:0]                s_axi_awready,
    input  logic [2*DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [2*DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic [1:0]                s_axi_wvalid,
    output logic [1:0]                s_axi_wready,
    output logic [2*RESP_WIDTH-1:0]   s_axi_bresp,
    output logic [1:0]                s_axi_bvalid,
    input  logic [1:0]                s_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [RESP_WIDTH-1:0]     m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [1:0]                grant
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t     state, state_next;
    logic [1:0] grant_next;
    logic [1:0] winner;
    logic       aw_done, aw_done_next;
    logic       w_done, w_done_next;
    logic       sel;
    logic       aw_hs, w_hs, b_hs;
`ifndef ARB_FIXED_PRIORITY_EN
    logic       rr_ptr, rr_ptr_next;
`endif

    // Index of the granted requester; only meaningful outside IDLE.
    assign sel   = grant[1];
    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;
    assign b_hs  = m_axi_bvalid & m_axi_bready;

    always_comb begin
        winner = 2'b00;
        case (s_axi_awvalid)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11: begin
`ifdef ARB_FIXED_PRIORITY_EN
                winner = 2'b01;
`else
                winner = rr_ptr ? 2'b10 : 2'b01;
`endif
            end
            default: winner = 2'b00;
        endcase
    end

    always_comb begin
        m_axi_awaddr  = sel ? s_axi_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_awaddr[ADDR_WIDTH-1:0];
        m_axi_wdata   = sel ? s_axi_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_axi_wdata[DATA_WIDTH-1:0];
        m_axi_wstrb   = sel ? s_axi_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : s_axi_wstrb[STRB_WIDTH-1:0];
        m_axi_awvalid = (state == XFER) && !aw_done && s_axi_awvalid[sel];
        m_axi_wvalid  = (state == XFER) && !w_done && s_axi_wvalid[sel];
        m_axi_bready  = (state == RESP) && s_axi_bready[sel];
        s_axi_awready = 2'b00;
        s_axi_wready  = 2'b00;
        s_axi_bvalid  = 2'b00;
        s_axi_bresp   = '0;
        if (state == XFER) begin
            s_axi_awready[sel] = m_axi_awready;
            s_axi_wready[sel]  = m_axi_wready;
        end
        if (state == RESP) begin
            s_axi_bvalid[sel] = m_axi_bvalid;
            if (sel)
                s_axi_bresp[2*RESP_WIDTH-1:RESP_WIDTH] = m_axi_bresp;
            else
                s_axi_bresp[RESP_WIDTH-1:0] = m_axi_bresp;
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        aw_done_next = aw_done;
        w_done_next  = w_done;
`ifndef ARB_FIXED_PRIORITY_EN
        rr_ptr_next  = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (|s_axi_awvalid) begin
                    grant_next = winner;
                    state_next = XFER;
                end
            end
            XFER: begin
                // AW and W complete independently; leave once both have been seen.
                aw_done_next = aw_done | aw_hs;
                w_done_next  = w_done | w_hs;
                if (aw_done_next && w_done_next)
                    state_next = RESP;
            end
            RESP: begin
                if (b_hs) begin
`ifndef ARB_FIXED_PRIORITY_EN
                    rr_ptr_next  = ~sel;
`endif
                    grant_next   = 2'b00;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                grant_next   = 2'b00;
                aw_done_next = 1'b0;
                w_done_next  = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state   <= IDLE;
            grant   <= 2'b00;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr  <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_ptr  <= rr_ptr_next;
`endif
        end
    end
endmodule

// File: tb/tb_axil_write_arbiter.sv
// tb/tb_axil_write_arbiter.sv - randomized self-checking bench for axil_write_arbiter
`timescale 1ns/1ps
module tb_axil_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 2;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } tx_t;

    logic            axi_aclk = 1'b0;
    logic            axi_areset = 1'b1;
    logic [2*AW-1:0] s_axi_awaddr = '0;
    logic [1:0]      s_axi_awvalid = '0;
    logic [1:0]      s_axi_awready;
    logic [2*DW-1:0] s_axi_wdata = '0;
    logic [2*SW-1:0] s_axi_wstrb = '0;
    logic [1:0]      s_axi_wvalid = '0;
    logic [1:0]      s_axi_wready;
    logic [2*RW-1:0] s_axi_bresp;
    logic [1:0]      s_axi_bvalid;
    logic [1:0]      s_axi_bready = '0;
    logic [AW-1:0]   m_axi_awaddr;
    logic            m_axi_awvalid;
    logic            m_axi_awready = 1'b0;
    logic [DW-1:0]   m_axi_wdata;
    logic [SW-1:0]   m_axi_wstrb;
    logic            m_axi_wvalid;
    logic            m_axi_wready = 1'b0;
    logic [RW-1:0]   m_axi_bresp = '0;
    logic            m_axi_bvalid = 1'b0;
    logic            m_axi_bready;
    logic [1:0]      grant;

    always #5 axi_aclk = ~axi_aclk;

    axil_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .grant(grant)
    );

    int errors = 0;
    int checks = 0;

    tx_t q0[$];
    tx_t q1[$];
    logic [AW-1:0] aw_log[$];
    bit  acc_aw[2];
    bit  acc_w[2];
    int  owner, last;
    bit  seen_aw, seen_w;
    int  hs_aw, hs_w, done_cnt, xfer_cyc, resp_cyc, last_resp_wait;
    int  p_awr = 100, p_wr = 100, p_bv = 100, p_br = 100;
    int  aw_delay = 0, b_hold = 0, bresp_fix = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expected);
        checks++;
        if (obs !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expected);
        end
    endtask

    function automatic tx_t rnd_tx(input logic [AW-1:0] a);
        tx_t t;
        t.addr = a;
        t.data = $urandom;
        t.strb = SW'($urandom);
        return t;
    endfunction

    function automatic tx_t head(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    // Arbitration rule: a lone requester wins; a tie goes to whoever was not served last.
    function automatic int pick(input logic [1:0] req);
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
`ifdef ARB_FIXED_PRIORITY_EN
        return 0;
`else
        return 1 - last;
`endif
    endfunction

    task automatic model_reset();
        owner = -1;
        last = 1;
        seen_aw = 0;
        seen_w = 0;
        done_cnt = 0;
        xfer_cyc = 0;
        resp_cyc = 0;
        acc_aw = '{0, 0};
        acc_w = '{0, 0};
        q0.delete();
        q1.delete();
        aw_log.delete();
    endtask

    task automatic drive();
        bit  resp_ph, pend;
        tx_t t;
        resp_ph = (owner >= 0) && seen_aw && seen_w;
        for (int i = 0; i < 2; i++) begin
            pend = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            t = pend ? head(i) : rnd_tx(AW'($urandom));
            s_axi_awaddr[i*AW +: AW] = t.addr;
            s_axi_wdata[i*DW +: DW]  = t.data;
            s_axi_wstrb[i*SW +: SW]  = t.strb;
            s_axi_awvalid[i] = pend && !acc_aw[i];
            s_axi_wvalid[i]  = pend && !acc_w[i];
            s_axi_bready[i]  = ($urandom_range(99) < p_br) && !(resp_ph && owner == i && resp_cyc < b_hold);
        end
        m_axi_awready = (xfer_cyc >= aw_delay) && ($urandom_range(99) < p_awr);
        m_axi_wready  = $urandom_range(99) < p_wr;
        m_axi_bvalid  = resp_ph && ($urandom_range(99) < p_bv);
        m_axi_bresp   = (bresp_fix >= 0) ? RW'(bresp_fix) : RW'($urandom);
    endtask

    task automatic sample();
        bit         resp_ph;
        logic [1:0] eg;
        tx_t        t;
        resp_ph = (owner >= 0) && seen_aw && seen_w;
        eg = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
        check("grant", grant, eg);
        for (int j = 0; j < 2; j++) begin
            if (owner != j)
                check("ungranted_side", {s_axi_awready[j], s_axi_wready[j], s_axi_bvalid[j], s_axi_bresp[j*RW +: RW]}, 0);
            if (s_axi_awvalid[j] && s_axi_awready[j]) acc_aw[j] = 1;
            if (s_axi_wvalid[j] && s_axi_wready[j]) acc_w[j] = 1;
        end
        if (owner < 0) begin
            check("idle_m", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
            if (|s_axi_awvalid) begin
                owner = pick(s_axi_awvalid);
                seen_aw = 0;
                seen_w = 0;
                hs_aw = 0;
                hs_w = 0;
                xfer_cyc = 0;
                resp_cyc = 0;
            end
            return;
        end
        t = head(owner);
        if (!resp_ph) begin
            check("m_awvalid", m_axi_awvalid, !seen_aw);
            check("m_wvalid", m_axi_wvalid, !seen_w);
            check("s_awready", s_axi_awready[owner], m_axi_awready);
            check("s_wready", s_axi_wready[owner], m_axi_wready);
            check("m_bready_xfer", m_axi_bready, 0);
            if (m_axi_awvalid && m_axi_awready) begin
                check("m_awaddr", m_axi_awaddr, t.addr);
                aw_log.push_back(m_axi_awaddr);
                hs_aw++;
                seen_aw = 1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("m_wdata_strb", {m_axi_wdata, m_axi_wstrb}, {t.data, t.strb});
                hs_w++;
                seen_w = 1;
            end
            xfer_cyc++;
        end else begin
            check("resp_quiet", {m_axi_awvalid, m_axi_wvalid, s_axi_awready[owner], s_axi_wready[owner]}, 0);
            check("s_bvalid", s_axi_bvalid[owner], m_axi_bvalid);
            check("s_bresp", s_axi_bresp[owner*RW +: RW], m_axi_bresp);
            check("m_bready", m_axi_bready, s_axi_bready[owner]);
            if (m_axi_bvalid && s_axi_bready[owner]) begin
                check("hs_count", {hs_aw, hs_w}, {32'd1, 32'd1});
                last_resp_wait = resp_cyc;
                if (owner == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                acc_aw[owner] = 0;
                acc_w[owner] = 0;
                last = owner;
                owner = -1;
                done_cnt++;
            end else begin
                resp_cyc++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge axi_aclk);
        drive();
        #1;
        sample();
    endtask

    task automatic run_until(input int target, input int max_cyc, output int used);
        used = 0;
        while (done_cnt < target && used < max_cyc) begin
            cycle();
            used++;
        end
        check("timeout", done_cnt, target);
    endtask

    task automatic do_reset();
        axi_areset = 1'b1;
        model_reset();
        drive();
        @(negedge axi_aclk);
        #1;
        check("rst_out", {grant, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                          m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
        axi_areset = 1'b0;
    endtask

    initial begin
        int n, total;
        logic [AW-1:0] a0;
        logic [AW-1:0] exp_tie [3];
        tx_t t;
`ifdef ARB_FIXED_PRIORITY_EN
        exp_tie = '{8'h10, 8'h10, 8'h10};
`else
        exp_tie = '{8'h10, 8'h14, 8'h10};
`endif

        // Single request from requester 0
        do_reset();
        t.addr = 8'h04; t.data = 32'hDEADBEEF; t.strb = 4'hF;
        q0.push_back(t);
        bresp_fix = 0;
        run_until(1, 50, n);
        check("single_latency", n, 3);
        check("single_addr", aw_log[0], 8'h04);
        cycle();

        // Tie for three transactions
        do_reset();
        for (int k = 0; k < 3; k++) begin
            q0.push_back(rnd_tx(8'h10));
            q1.push_back(rnd_tx(8'h14));
        end
        run_until(3, 100, n);
        for (int k = 0; k < 3; k++) check("tie_order", aw_log[k], exp_tie[k]);

        // W accepted two cycles before AW
        do_reset();
        q1.push_back(rnd_tx(AW'($urandom)));
        aw_delay = 2;
        run_until(1, 50, n);
        check("split_xfer_cycles", xfer_cyc, 3);
        aw_delay = 0;

        // Response backpressure on requester 1
        do_reset();
        q1.push_back(rnd_tx(AW'($urandom)));
        b_hold = 4;
        bresp_fix = 2;
        run_until(1, 50, n);
        check("b_wait", last_resp_wait, 4);
        b_hold = 0;

        // Reset while requester 1 is mid-transfer
        do_reset();
        q1.push_back(rnd_tx(AW'($urandom)));
        aw_delay = 1000;
        p_wr = 0;
        repeat (3) cycle();
        check("pre_rst_grant", grant, 2'b10);
        #2;
        axi_areset = 1'b1;
        #1;
        check("async_rst", {grant, s_axi_awready, s_axi_wready, s_axi_bvalid,
                            m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
        do_reset();
        aw_delay = 0;
        p_wr = 100;
        q0.push_back(rnd_tx(AW'($urandom)));
        q1.push_back(rnd_tx(AW'($urandom)));
        a0 = q0[0].addr;
        run_until(1, 50, n);
        check("post_rst_winner", aw_log[0], a0);

        // Randomized traffic
        bresp_fix = -1;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            p_awr = $urandom_range(100, 30);
            p_wr  = $urandom_range(100, 30);
            p_bv  = $urandom_range(100, 30);
            p_br  = $urandom_range(100, 30);
            repeat ($urandom_range(15, 5)) q0.push_back(rnd_tx(AW'($urandom)));
            repeat ($urandom_range(15, 5)) q1.push_back(rnd_tx(AW'($urandom)));
            total = q0.size() + q1.size();
            run_until(total, 4000, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
